mem_bus_n: RTL and testbench

Parametrised CPU-to-peripheral interconnect. It connects one CPU master port to `NS` slave ports and selects the slave from an address bit field. Unlike the fixed two-way RAM/UART split, it tracks one outstanding transaction in a small FSM and waits for a per-slave ready. It registers read data, flags unmapped accesses, and can optionally time out a stalled slave.

---
 rtl/mem_bus_n.sv | 198 +++++++++++++++++++
 tb/tb_mem_bus_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_n.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_n
//  Purpose  : CPU-to-peripheral interconnect with NS slave ports. The slave
//             is picked from an address bit field. One outstanding
//             transaction is tracked by a small FSM that waits for the
//             selected slave's ready. Read data is registered, and unmapped
//             accesses are flagged with an error pulse.
//  Options  : MEM_BUS_N_TIMEOUT_EN - when defined, a stalled slave is
//             aborted after TIMEOUT_CYC waiting cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_n #(
    parameter int NS          = 2,
    parameter int SEL_LSB     = 22,
    parameter int SEL_W       = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic                cpu_rstrb_i,
    input  logic [3:0]          cpu_wmask_i,
    input  logic [31:0]         cpu_wdata_i,
    output logic [31:0]         cpu_rdata_o,
    output logic                cpu_busy_o,
    output logic                cpu_err_o,
    output logic [31:0]         s_addr_o,
    output logic [31:0]         s_wdata_o,
    output logic [NS-1:0]       s_rstrb_o,
    output logic [4*NS-1:0]     s_wmask_o,
    input  logic [32*NS-1:0]    s_rdata_i,
    input  logic [NS-1:0]       s_ready_i
);

    // Catch illegal parameter combinations at elaboration time.
    generate
        if (NS < 1 || NS > 8 || (1 << SEL_W) < NS || SEL_LSB + SEL_W > 32 ||
            TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
            $error("mem_bus_n: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   w_idx;
    logic               w_mapped;
    logic               w_wr_req;
    logic               w_ready_sel;
    logic [31:0]        w_rdata_sel;
    logic               w_expire;

    // Address and write data go to every slave unchanged; only strobes are steered.
    assign s_addr_o  = cpu_addr_i;
    assign s_wdata_o = cpu_wdata_i;

    assign w_idx     = cpu_addr_i[SEL_LSB +: SEL_W];
    assign w_mapped  = (int'(w_idx) < NS);
    assign w_wr_req  = (cpu_wmask_i != 4'b0000);

    // Pick ready and read data of the slave latched at request time.
    always_comb begin
        w_ready_sel = 1'b0;
        w_rdata_sel = 32'h0000_0000;
        for (int k = 0; k < NS; k++) begin
            if (int'(sel_q) == k) begin
                w_ready_sel = s_ready_i[k];
                w_rdata_sel = s_rdata_i[32*k +: 32];
            end
        end
    end

`ifdef MEM_BUS_N_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        w_waiting;

    assign w_waiting = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    // Expire in the waiting cycle where the counter would reach the limit.
    assign w_expire  = w_waiting && ((tcnt_q + 16'd1) == 16'(TIMEOUT_CYC));

    // Wait counter: held at zero in IDLE so every wait starts from zero.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == ST_IDLE) begin
            tcnt_d = 16'd0;
        end else if (w_waiting) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= 16'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Next-state logic; slave strobes are only ever raised in IDLE outside reset.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        s_rstrb_o = '0;
        s_wmask_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (!rst_i) begin
                    if (w_wr_req) begin
                        // A write wins over a simultaneous read.
                        if (w_mapped) begin
                            for (int k = 0; k < NS; k++) begin
                                if (int'(w_idx) == k) begin
                                    s_wmask_o[4*k +: 4] = cpu_wmask_i;
                                end
                            end
                            sel_d   = w_idx;
                            state_d = ST_WR_WAIT;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end else if (cpu_rstrb_i) begin
                        if (w_mapped) begin
                            for (int k = 0; k < NS; k++) begin
                                if (int'(w_idx) == k) begin
                                    s_rstrb_o[k] = 1'b1;
                                end
                            end
                            sel_d   = w_idx;
                            state_d = ST_RD_WAIT;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (w_ready_sel) begin
                    rdata_d = w_rdata_sel;
                    state_d = ST_IDLE;
                end else if (w_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WR_WAIT: begin
                if (w_ready_sel) begin
                    state_d = ST_IDLE;
                end else if (w_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                rdata_d = 32'h0000_0000;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, selection, read data and error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_err_o   = err_q;
    assign cpu_busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_n
//  Purpose  : Self-checking bench for mem_bus_n (NS=3, SEL_W=2, SEL_LSB=22).
//             Table of transactions plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_n;

    localparam int NS = 3;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [31:0]        cpu_addr_i;
    logic               cpu_rstrb_i;
    logic [3:0]         cpu_wmask_i;
    logic [31:0]        cpu_wdata_i;
    logic [31:0]        cpu_rdata_o;
    logic               cpu_busy_o;
    logic               cpu_err_o;
    logic [31:0]        s_addr_o;
    logic [31:0]        s_wdata_o;
    logic [NS-1:0]      s_rstrb_o;
    logic [4*NS-1:0]    s_wmask_o;
    logic [32*NS-1:0]   s_rdata_i;
    logic [NS-1:0]      s_ready_i;

    int checks = 0;
    int errors = 0;

    mem_bus_n #(
        .NS          (NS),
        .SEL_LSB     (22),
        .SEL_W       (2),
        .TIMEOUT_CYC (8)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_rstrb_i (cpu_rstrb_i),
        .cpu_wmask_i (cpu_wmask_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_busy_o  (cpu_busy_o),
        .cpu_err_o   (cpu_err_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rstrb_o   (s_rstrb_o),
        .s_wmask_o   (s_wmask_o),
        .s_rdata_i   (s_rdata_i),
        .s_ready_i   (s_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        rstrb;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          slave;      // slave that answers, -1 for none
        int          delay;      // cycles after request when ready pulses
        logic [31:0] sdata;
        logic [2:0]  exp_rstrb;
        logic [11:0] exp_wmask;
        int          exp_busy;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int busy_cnt;
        bit done;
        busy_cnt = 0;
        done     = 1'b0;
        tick();
        cpu_addr_i  = v.addr;
        cpu_rstrb_i = v.rstrb;
        cpu_wmask_i = v.wmask;
        cpu_wdata_i = v.wdata;
        @(negedge clk_i);
        check($sformatf("v%0d rstrb", n), 32'(s_rstrb_o), 32'(v.exp_rstrb));
        check($sformatf("v%0d wmask", n), 32'(s_wmask_o), 32'(v.exp_wmask));
        check($sformatf("v%0d s_addr", n), s_addr_o, v.addr);
        check($sformatf("v%0d s_wdata", n), s_wdata_o, v.wdata);
        tick();
        cpu_rstrb_i = 1'b0;
        cpu_wmask_i = 4'b0000;
        for (int c = 1; c <= 300 && !done; c++) begin
            if (c == v.delay && v.slave >= 0) begin
                s_ready_i[v.slave]            = 1'b1;
                s_rdata_i[32*v.slave +: 32]   = v.sdata;
            end
            @(negedge clk_i);
            if (cpu_busy_o) begin
                busy_cnt++;
            end else begin
                done = 1'b1;
                check($sformatf("v%0d busy_cycles", n), 32'(busy_cnt), 32'(v.exp_busy));
                check($sformatf("v%0d rdata", n), cpu_rdata_o, v.exp_rdata);
                check($sformatf("v%0d err", n), 32'(cpu_err_o), 32'(v.exp_err));
            end
            tick();
            s_ready_i = '0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d busy_timeout: busy still 1 after 300 cycles, expected release", n);
        end
    endtask

    initial begin
        //            addr          rd    wmask    wdata          slv dly sdata          exp_rs  exp_wm          busy exp_rdata      err
        vecs[0] = '{32'h0000_0010, 1'b1, 4'b0000, 32'h0000_0000,  0,  1, 32'h1234_5678, 3'b001, 12'h000,          1, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'h0040_0004, 1'b0, 4'b0011, 32'hA5A5_A5A5,  1,  3, 32'hDEAD_BEEF, 3'b000, 12'b0000_0011_0000, 3, 32'h1234_5678, 1'b0};
        vecs[2] = '{32'h00C0_0000, 1'b1, 4'b0000, 32'h0000_0000, -1,  0, 32'h0000_0000, 3'b000, 12'h000,          1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0080_0008, 1'b1, 4'b0000, 32'h0000_0000,  2,  2, 32'hCAFE_F00D, 3'b100, 12'h000,          2, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_0020, 1'b1, 4'b1111, 32'h0BAD_F00D,  0,  1, 32'h1111_1111, 3'b000, 12'h00F,          1, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{32'h00C0_0004, 1'b0, 4'b1000, 32'h5555_AAAA, -1,  0, 32'h0000_0000, 3'b000, 12'h000,          1, 32'h0000_0000, 1'b1};
`ifdef MEM_BUS_N_TIMEOUT_EN
        // Slave 2 never answers: abort after 8 waiting cycles plus the ERR cycle.
        vecs[6] = '{32'h0080_0000, 1'b1, 4'b0000, 32'h0000_0000, -1,  0, 32'h0000_0000, 3'b100, 12'h000,          9, 32'h0000_0000, 1'b1};
`else
        // Slave 2 stalls 120 cycles; the bus must keep waiting.
        vecs[6] = '{32'h0080_0000, 1'b1, 4'b0000, 32'h0000_0000,  2, 120, 32'h7777_0120, 3'b100, 12'h000,       120, 32'h7777_0120, 1'b0};
`endif
        vecs[7] = '{32'h0040_0000, 1'b1, 4'b0000, 32'h0000_0000,  1,  1, 32'h8765_4321, 3'b010, 12'h000,          1, 32'h8765_4321, 1'b0};

        rst_i       = 1'b1;
        cpu_addr_i  = 32'h0;
        cpu_rstrb_i = 1'b0;
        cpu_wmask_i = 4'b0000;
        cpu_wdata_i = 32'h0;
        s_rdata_i   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        s_ready_i   = '0;

        // Reset state.
        repeat (3) tick();
        @(negedge clk_i);
        check("reset busy", 32'(cpu_busy_o), 32'd0);
        check("reset rdata", cpu_rdata_o, 32'h0);
        check("reset err", 32'(cpu_err_o), 32'd0);
        check("reset rstrb", 32'(s_rstrb_o), 32'd0);
        check("reset wmask", 32'(s_wmask_o), 32'd0);
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Ready from a non-selected slave must not complete a read.
        tick();
        cpu_addr_i  = 32'h0000_0040;
        cpu_rstrb_i = 1'b1;
        @(negedge clk_i);
        check("foreign rstrb", 32'(s_rstrb_o), 32'b001);
        tick();
        cpu_rstrb_i            = 1'b0;
        s_ready_i              = 3'b010;
        s_rdata_i[63:32]       = 32'hBAD0_BAD0;
        @(negedge clk_i);
        check("foreign busy T+1", 32'(cpu_busy_o), 32'd1);
        tick();
        s_ready_i = '0;
        @(negedge clk_i);
        check("foreign busy T+2", 32'(cpu_busy_o), 32'd1);
        check("foreign rdata held", cpu_rdata_o, 32'h8765_4321);
        tick();
        s_ready_i        = 3'b001;
        s_rdata_i[31:0]  = 32'h0F0F_0F0F;
        tick();
        s_ready_i = '0;
        @(negedge clk_i);
        check("foreign busy done", 32'(cpu_busy_o), 32'd0);
        check("foreign rdata", cpu_rdata_o, 32'h0F0F_0F0F);

        // Reset during RD_WAIT, then a late ready that must be ignored.
        tick();
        cpu_addr_i  = 32'h0080_0000;
        cpu_rstrb_i = 1'b1;
        tick();
        cpu_rstrb_i = 1'b0;
        rst_i       = 1'b1;
        @(negedge clk_i);
        check("rst busy before edge", 32'(cpu_busy_o), 32'd1);
        tick();
        rst_i             = 1'b0;
        s_ready_i         = 3'b100;
        s_rdata_i[95:64]  = 32'h55AA_55AA;
        @(negedge clk_i);
        check("rst busy after", 32'(cpu_busy_o), 32'd0);
        check("rst rdata after", cpu_rdata_o, 32'h0);
        check("rst err after", 32'(cpu_err_o), 32'd0);
        tick();
        s_ready_i = '0;
        @(negedge clk_i);
        check("late ready busy", 32'(cpu_busy_o), 32'd0);
        check("late ready rdata", cpu_rdata_o, 32'h0);

        // Requests while reset is asserted must not reach any slave.
        tick();
        rst_i       = 1'b1;
        cpu_addr_i  = 32'h0040_0000;
        cpu_rstrb_i = 1'b1;
        cpu_wmask_i = 4'b1111;
        @(negedge clk_i);
        check("rst gate rstrb", 32'(s_rstrb_o), 32'd0);
        check("rst gate wmask", 32'(s_wmask_o), 32'd0);
        tick();
        rst_i       = 1'b0;
        cpu_rstrb_i = 1'b0;
        cpu_wmask_i = 4'b0000;
        @(negedge clk_i);
        check("rst gate busy", 32'(cpu_busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
